// File: rtl/biriscv_branch_upd_arb.sv
// Merges resolved-branch records from both execute lanes into an in-order FIFO.
// The FIFO drains one record per cycle to the branch-predictor update port.
module biriscv_branch_upd_arb #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     br0_valid_i,
  input  logic                     br0_taken_i,
  input  logic [31:0]              br0_source_i,
  input  logic [31:0]              br0_pc_i,
  input  logic                     br0_is_call_i,
  input  logic                     br0_is_ret_i,
  input  logic                     br0_is_jmp_i,
  input  logic                     br1_valid_i,
  input  logic                     br1_taken_i,
  input  logic [31:0]              br1_source_i,
  input  logic [31:0]              br1_pc_i,
  input  logic                     br1_is_call_i,
  input  logic                     br1_is_ret_i,
  input  logic                     br1_is_jmp_i,
  output logic                     upd_valid_o,
  input  logic                     upd_ready_i,
  output logic                     upd_taken_o,
  output logic [31:0]              upd_source_o,
  output logic [31:0]              upd_pc_o,
  output logic                     upd_is_call_o,
  output logic                     upd_is_ret_o,
  output logic                     upd_is_jmp_o,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [15:0]              drop_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        taken;
    logic [31:0] source;
    logic [31:0] pc;
    logic        is_call;
    logic        is_ret;
    logic        is_jmp;
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_q, drop_d;

  rec_t          in0, in1, first_rec;
  logic          lane1_live;
  logic          deq;
  logic [1:0]    n_in, n_enq, n_drop;
  logic [CW:0]   free_slots;
  logic [16:0]   drop_sum;

  always_comb begin
    in0 = '{taken: br0_taken_i, source: br0_source_i, pc: br0_pc_i,
            is_call: br0_is_call_i, is_ret: br0_is_ret_i, is_jmp: br0_is_jmp_i};
    in1 = '{taken: br1_taken_i, source: br1_source_i, pc: br1_pc_i,
            is_call: br1_is_call_i, is_ret: br1_is_ret_i, is_jmp: br1_is_jmp_i};

    // A taken lane-0 branch means lane 1 executed on the wrong path.
    lane1_live = br1_valid_i && !(br0_valid_i && br0_taken_i);
    n_in       = {1'b0, br0_valid_i} + {1'b0, lane1_live};
    first_rec  = br0_valid_i ? in0 : in1;

    deq        = (count_q != '0) && upd_ready_i;
    free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(deq);

    // Incoming count never exceeds two, so a shortfall leaves free_slots at 0 or 1.
    if (free_slots >= (CW+1)'(n_in)) n_enq = n_in;
    else                              n_enq = free_slots[1:0];
    n_drop = n_in - n_enq;

    wr_ptr_nx = wr_ptr_q + 1'b1;
    mem_d     = mem_q;
    if (n_enq != 2'd0) mem_d[wr_ptr_q]  = first_rec;
    if (n_enq == 2'd2) mem_d[wr_ptr_nx] = in1;

    wr_ptr_d = wr_ptr_q + AW'(n_enq);
    rd_ptr_d = rd_ptr_q + AW'(deq);
    count_d  = count_q + CW'(n_enq) - CW'(deq);

    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign upd_valid_o   = (count_q != '0);
  assign upd_taken_o   = mem_q[rd_ptr_q].taken;
  assign upd_source_o  = mem_q[rd_ptr_q].source;
  assign upd_pc_o      = mem_q[rd_ptr_q].pc;
  assign upd_is_call_o = mem_q[rd_ptr_q].is_call;
  assign upd_is_ret_o  = mem_q[rd_ptr_q].is_ret;
  assign upd_is_jmp_o  = mem_q[rd_ptr_q].is_jmp;
  assign stall_o       = (count_q > CW'(DEPTH - 2));
  assign occupancy_o   = count_q;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_biriscv_branch_upd_arb.sv
// Directed and randomized checks of the branch-update arbiter against a
// queue-based model of the record stream, squash and drop accounting.
module tb_biriscv_branch_upd_arb;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        taken;
    logic [31:0] source;
    logic [31:0] pc;
    logic        is_call;
    logic        is_ret;
    logic        is_jmp;
  } rec_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic v0, v1, upd_ready_i;
  rec_t r0, r1;

  logic                    upd_valid_o, upd_taken_o, upd_is_call_o, upd_is_ret_o, upd_is_jmp_o;
  logic [31:0]             upd_source_o, upd_pc_o;
  logic                    stall_o;
  logic [$clog2(DEPTH):0]  occupancy_o;
  logic [15:0]             drop_count_o;

  int   total  = 0;
  int   passed = 0;
  rec_t q[$];
  int   drops  = 0;

  always #5 clk_i = ~clk_i;

  biriscv_branch_upd_arb #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .br0_valid_i(v0), .br0_taken_i(r0.taken), .br0_source_i(r0.source), .br0_pc_i(r0.pc),
    .br0_is_call_i(r0.is_call), .br0_is_ret_i(r0.is_ret), .br0_is_jmp_i(r0.is_jmp),
    .br1_valid_i(v1), .br1_taken_i(r1.taken), .br1_source_i(r1.source), .br1_pc_i(r1.pc),
    .br1_is_call_i(r1.is_call), .br1_is_ret_i(r1.is_ret), .br1_is_jmp_i(r1.is_jmp),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
    .upd_taken_o(upd_taken_o), .upd_source_o(upd_source_o), .upd_pc_o(upd_pc_o),
    .upd_is_call_o(upd_is_call_o), .upd_is_ret_o(upd_is_ret_o), .upd_is_jmp_o(upd_is_jmp_o),
    .stall_o(stall_o), .occupancy_o(occupancy_o), .drop_count_o(drop_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic rec_t mk(input logic tk, input logic [31:0] src);
    rec_t r;
    r.taken   = tk;
    r.source  = src;
    r.pc      = tk ? (src ^ 32'h0000_0800) : src + 32'd4;
    r.is_call = 1'b0;
    r.is_ret  = 1'b0;
    r.is_jmp  = tk;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    rec_t r;
    r.taken   = 1'($urandom_range(0, 1));
    r.source  = $urandom & 32'hFFFF_FFFC;
    r.pc      = $urandom & 32'hFFFF_FFFC;
    r.is_call = 1'($urandom_range(0, 1));
    r.is_ret  = 1'($urandom_range(0, 1));
    r.is_jmp  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drive(input logic nv0, input rec_t nr0, input logic nv1, input rec_t nr1);
    v0 = nv0; r0 = nr0; v1 = nv1; r1 = nr1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  // Reference: pop the head if handshaken, then append survivors in lane order
  // while room remains; anything else is a drop.
  task automatic model_edge();
    rec_t incoming[$];
    if (rst_i) begin
      q.delete();
      drops = 0;
    end else begin
      if (q.size() > 0 && upd_ready_i) void'(q.pop_front());
      if (v0) incoming.push_back(r0);
      if (v1 && !(v0 && r0.taken)) incoming.push_back(r1);
      foreach (incoming[i]) begin
        if (q.size() < DEPTH) q.push_back(incoming[i]);
        else drops = (drops < 65535) ? drops + 1 : 65535;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(upd_valid_o), 32'(q.size() != 0));
    check("occupancy", 32'(occupancy_o), 32'(q.size()));
    check("stall", 32'(stall_o), 32'(q.size() > DEPTH - 2));
    check("drop_count", 32'(drop_count_o), 32'(drops));
    if (q.size() != 0) begin
      check("head_taken", 32'(upd_taken_o), 32'(q[0].taken));
      check("head_source", upd_source_o, q[0].source);
      check("head_pc", upd_pc_o, q[0].pc);
      check("head_flags", 32'({upd_is_call_o, upd_is_ret_o, upd_is_jmp_o}),
            32'({q[0].is_call, q[0].is_ret, q[0].is_jmp}));
    end
  endtask

  task automatic step(input bit chk);
    @(posedge clk_i);
    #1;
    model_edge();
    if (chk) compare_all();
  endtask

  initial begin
    rec_t a, b;
    rst_i = 1'b1;
    upd_ready_i = 1'b0;
    idle();
    step(1);
    step(1);
    check("rst_source", upd_source_o, 32'h0);
    check("rst_pc", upd_pc_o, 32'h0);
    check("rst_taken", 32'(upd_taken_o), 32'h0);
    rst_i = 1'b0;

    // single lane 0, not taken
    upd_ready_i = 1'b1;
    drive(1'b1, mk(1'b0, 32'h100), 1'b0, '0);
    step(1);
    check("t1_pc", upd_pc_o, 32'h104);
    idle();
    step(1);

    // both lanes, neither taken
    drive(1'b1, mk(1'b0, 32'h200), 1'b1, mk(1'b0, 32'h204));
    step(1);
    check("t2_first", upd_source_o, 32'h200);
    idle();
    step(1);
    check("t2_second", upd_source_o, 32'h204);
    step(1);

    // lane 0 taken squashes lane 1
    a = mk(1'b1, 32'h300);
    a.pc = 32'h800;
    drive(1'b1, a, 1'b1, mk(1'b0, 32'h304));
    step(1);
    check("t3_pc", upd_pc_o, 32'h800);
    check("t3_occ", 32'(occupancy_o), 32'd1);
    idle();
    step(1);

    // fill with ready low, overflow by two
    upd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(1'b0, 32'h1000 + 32'(16 * i)), 1'b1, mk(1'b0, 32'h1004 + 32'(16 * i)));
      step(1);
    end
    check("t4_drops", 32'(drop_count_o), 32'd2);
    check("t4_head", upd_source_o, 32'h1000);

    // full, dequeue frees one slot for lane 0 only
    upd_ready_i = 1'b1;
    drive(1'b1, mk(1'b0, 32'h2000), 1'b1, mk(1'b0, 32'h2004));
    step(1);
    check("t5_occ", 32'(occupancy_o), 32'd4);
    idle();
    for (int i = 0; i < 4; i++) step(1);

    // reset mid-operation, inputs ignored while held
    upd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(1'b0, 32'h3000 + 32'(16 * i)), 1'b1, mk(1'b0, 32'h3004 + 32'(16 * i)));
      step(1);
    end
    rst_i = 1'b1;
    upd_ready_i = 1'b1;
    step(1);
    check("rst_mid_drops", 32'(drop_count_o), 32'd0);
    rst_i = 1'b0;
    b = rnd_rec();
    drive(1'b1, b, 1'b0, '0);
    step(1);
    idle();
    step(1);

    // randomized traffic, upstream sometimes ignores stall
    for (int i = 0; i < 400; i++) begin
      upd_ready_i = ($urandom_range(0, 9) < 7);
      rst_i = ($urandom_range(0, 149) == 0);
      if (stall_o && $urandom_range(0, 3) != 0) idle();
      else drive(1'($urandom_range(0, 1)), rnd_rec(), 1'($urandom_range(0, 1)), rnd_rec());
      step(1);
    end
    rst_i = 1'b0;

    // drive the drop counter into saturation
    rst_i = 1'b1;
    idle();
    step(1);
    rst_i = 1'b0;
    upd_ready_i = 1'b0;
    drive(1'b1, mk(1'b0, 32'h4000), 1'b1, mk(1'b0, 32'h4004));
    for (int i = 0; i < 32769; i++) step(0);
    check("sat_fffe", 32'(drop_count_o), 32'h0000_FFFE);
    step(1);
    check("sat_ffff", 32'(drop_count_o), 32'h0000_FFFF);
    step(1);
    check("sat_hold", 32'(drop_count_o), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
